// File: rtl/adder_feeder_pkg.sv
// Shared constants, pointer-width helper and operand-pair type for the adder operand feeder.
package adder_feeder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Number of index bits for a power-of-two depth; pointers add one wrap bit on top.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/adder_operand_feeder_fifo.sv
// Operand-pair FIFO: storage, wrap-bit pointers, full/empty flags and occupancy.
module feeder_pair_fifo
    import adder_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_a,
    input  logic [WIDTH-1:0]      push_b,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_a,
    output logic [WIDTH-1:0]      head_b,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{a: push_a, b: push_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level  = wr_ptr - rd_ptr;
    assign head_a = mem[rd_ptr[AW-1:0]].a;
    assign head_b = mem[rd_ptr[AW-1:0]].b;

endmodule

// File: rtl/adder_operand_feeder.sv
// Flow-controlled wrapper around a combinational adder: operand FIFO in, registered sum out.
// Optional signed-overflow flag output is enabled by defining ADDER_FEEDER_OVF_EN.
module adder_operand_feeder
    import adder_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_sum,
`ifdef ADDER_FEEDER_OVF_EN
    output logic                  out_ovf,
`endif
    output logic [clog2(DEPTH):0] level
);

    logic             push;
    logic             load;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    // in_ready depends only on registered pointers, so a full FIFO never admits a push even while popping.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign load     = !empty && (!out_valid || out_ready);

    feeder_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (load),
        .head_a (head_a),
        .head_b (head_b),
        .empty  (empty),
        .full   (full),
        .level  (level)
    );

    assign add_a = empty ? '0 : head_a;
    assign add_b = empty ? '0 : head_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADDER_FEEDER_OVF_EN
    logic ovf_next;

    assign ovf_next = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (load) begin
            out_ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Scoreboard bench for adder_operand_feeder; an ideal adder closes the add_a/add_b -> add_sum loop.
module tb_adder_operand_feeder;
    import adder_feeder_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int DEPTH = DEFAULT_DEPTH;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } expect_t;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_a;
    logic [WIDTH-1:0]      in_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_sum;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_sum;
    logic [clog2(DEPTH):0] level;
`ifdef ADDER_FEEDER_OVF_EN
    logic                  out_ovf;
`endif

    int      checks;
    int      fails;
    expect_t sb[$];

    adder_operand_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef ADDER_FEEDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .level     (level)
    );

    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Holds in_valid with the pair until a handshake edge or the cycle budget runs out; returns at posedge+1.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] exp_sum, input logic exp_ovf,
                                 input int max_cycles, output logic accepted);
        expect_t e;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum = exp_sum;
                e.ovf = exp_ovf;
                sb.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expect_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_sum", out_sum, e.sum);
`ifdef ADDER_FEEDER_OVF_EN
                checkOutput("out_ovf", {{(WIDTH-1){1'b0}}, out_ovf}, {{(WIDTH-1){1'b0}}, e.ovf});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic             acc;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] rs;
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        #3;
        checkOutput("reset_out_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        checkOutput("reset_out_sum", out_sum, '0);
        checkOutput("reset_level", WIDTH'(level), '0);
        checkOutput("reset_in_ready", {{(WIDTH-1){1'b0}}, in_ready}, 1);
        checkOutput("reset_add_a", add_a, '0);
        checkOutput("reset_add_b", add_b, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single pair 5+7");
        applyStimulus(32'd5, 32'd7, 32'd12, 1'b0, 4, acc);
        in_valid = 1'b0;
        checkOutput("single_accepted", {{(WIDTH-1){1'b0}}, acc}, 1);
        checkOutput("single_valid_after_N", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        checkOutput("single_level_after_N", WIDTH'(level), 1);
        checkOutput("single_head_a", add_a, 32'd5);
        @(posedge clk);
        #1;
        checkOutput("single_valid_after_N1", {{(WIDTH-1){1'b0}}, out_valid}, 1);
        checkOutput("single_sum_after_N1", out_sum, 32'd12);
        @(posedge clk);
        #1;
        checkOutput("single_valid_drops", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        checkOutput("single_sum_holds", out_sum, 32'd12);
        checkOutput("empty_head_a_zero", add_a, '0);

        $display("[TB] wrap-around and overflow vectors");
        applyStimulus(32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 4, acc);
        applyStimulus(32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 4, acc);
        applyStimulus(32'h80000000, 32'h80000000, 32'h0, 1'b1, 4, acc);
        idleCycles(4);

        $display("[TB] back-pressure until full");
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(WIDTH'(k), WIDTH'(k), WIDTH'(2 * k), 1'b0, 4, acc);
            checkOutput("bp_accepted", {{(WIDTH-1){1'b0}}, acc}, 1);
        end
        applyStimulus(32'd6, 32'd6, 32'd12, 1'b0, 3, acc);
        in_valid = 1'b0;
        checkOutput("bp_sixth_refused", {{(WIDTH-1){1'b0}}, acc}, '0);
        checkOutput("bp_in_ready_low", {{(WIDTH-1){1'b0}}, in_ready}, '0);
        checkOutput("bp_level_full", WIDTH'(level), DEPTH);
        checkOutput("bp_stall_sum", out_sum, 32'd2);
        out_ready = 1'b1;
        idleCycles(8);
        checkOutput("bp_drained_level", WIDTH'(level), '0);

        $display("[TB] full with simultaneous pop");
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(WIDTH'(10 * k), 32'd3, WIDTH'(10 * k + 3), 1'b0, 4, acc);
        end
        in_valid = 1'b0;
        in_a      = 32'd100;
        in_b      = 32'd200;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("fsp_in_ready_low", {{(WIDTH-1){1'b0}}, in_ready}, '0);
        checkOutput("fsp_level_full", WIDTH'(level), DEPTH);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("fsp_level_dropped", WIDTH'(level), DEPTH - 1);
        checkOutput("fsp_in_ready_high", {{(WIDTH-1){1'b0}}, in_ready}, 1);
        if (in_ready) begin
            sb.push_back('{sum: 32'd300, ovf: 1'b0});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("fsp_level_push_pop", WIDTH'(level), DEPTH - 1);
        idleCycles(8);

        $display("[TB] streaming 100 pairs");
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = ra + rb;
            applyStimulus(ra, rb, rs, (ra[WIDTH-1] == rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]), 4, acc);
            checkOutput("stream_level_le1", {{(WIDTH-1){1'b0}}, (level <= 1)}, 1);
            if (i > 0) begin
                checkOutput("stream_out_valid", {{(WIDTH-1){1'b0}}, out_valid}, 1);
            end
        end
        idleCycles(4);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(WIDTH'(k), 32'd1000, WIDTH'(k + 1000), 1'b0, 4, acc);
        end
        in_valid = 1'b0;
        checkOutput("rst_pre_level", WIDTH'(level), 3);
        checkOutput("rst_pre_valid", {{(WIDTH-1){1'b0}}, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rst_async_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        checkOutput("rst_async_sum", out_sum, '0);
        checkOutput("rst_async_level", WIDTH'(level), '0);
        checkOutput("rst_async_in_ready", {{(WIDTH-1){1'b0}}, in_ready}, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idleCycles(5);
        checkOutput("rst_no_stale_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
        applyStimulus(32'd40, 32'd2, 32'd42, 1'b0, 4, acc);
        idleCycles(4);

        checkOutput("scoreboard_empty", WIDTH'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_operand_feeder.md
Name: adder_operand_feeder

Overview:
- Upstream/downstream wrapper stage for the combinational N-bit adder.
- Buffers incoming operand pairs in a small FIFO and presents the head pair on the adder's operand inputs.
- Captures the adder's combinational sum into a registered output with valid/ready handshake.
- Converts the purely combinational adder into a flow-controlled, back-pressurable pipeline stage.

Parameters:
- WIDTH, 32, operand/sum width; matches the adder's a/b/out width.
- DEPTH, 4, operand-pair FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- add_a  output  WIDTH  to adder input a (head entry A).
- add_b  output  WIDTH  to adder input b (head entry B).
- add_sum  input  WIDTH  from adder output out (combinational).
- out_valid  output  1  registered sum valid.
- out_ready  input  1  downstream accepts sum.
- out_sum  output  WIDTH  registered sum.
- level  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_sum=0, in_ready=1, add_a=add_b=0. FIFO storage is not reset.
- Pointers: clog2(DEPTH)+1 bits with wrap bit.
  - empty = (wr_ptr==rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push: in_valid && in_ready at a rising edge writes {in_a,in_b} at wr_ptr and increments wr_ptr.
- in_ready = !full, combinational from registered pointers only.
  - No same-cycle bypass: when full, a simultaneous pop does not admit a push in that cycle.
- Head drive:
  - add_a/add_b = mem[rd_ptr] when !empty.
  - add_a/add_b = 0 when empty, so the adder sees stable zeros.
- Pop/load condition: load = !empty && (!out_valid || out_ready). On load:
  - out_sum <= add_sum.
  - out_valid <= 1.
  - rd_ptr increments.
- Drain: out_valid && out_ready && !load → out_valid <= 0. out_sum holds its last value.
- Stall: out_valid && !out_ready → out_sum and out_valid hold; no pop.
- Arithmetic: out_sum is (a+b) mod 2^WIDTH as produced by the adder; carry-out is discarded.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
  - Push into an empty FIFO is not visible for pop until the next cycle.
- Latency: in handshake at edge N → out_valid=1 after edge N+1 when the stage is idle.
- Throughput: 1 sum/cycle with out_ready held high.
- Reset mid-operation: all queued pairs and any pending out_sum are discarded immediately; no output is produced afterwards until new pushes.
- level = wr_ptr - rd_ptr (modulo pointer width). Range 0..DEPTH.

Optional Feature:
- Macro: ADDER_FEEDER_OVF_EN.
- Defined: adds output port out_ovf (1 bit), reset 0.
  - Loaded with out_sum on each load.
  - Value = signed overflow: (add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]).
  - Holds with out_sum during stall.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package adder_feeder_pkg:
  - default WIDTH/DEPTH constants.
  - pointer-width function clog2.
  - operand-pair struct/typedef {a,b}.
- One natural sub-module: feeder_pair_fifo.
  - Holds storage, pointers, full/empty and level.
  - Top module holds head muxing, the output register and the optional overflow logic.

Test Plan:
- Single pair: push a=5, b=7 with out_ready=1 → out_valid rises one cycle after the handshake edge, out_sum=12, then out_valid drops.
- Wrap-around sum: a=32'hFFFFFFFF, b=2 → out_sum=1.
  - With ADDER_FEEDER_OVF_EN: out_ovf=0.
  - Then a=32'h7FFFFFFF, b=1 → out_sum=32'h80000000, out_ovf=1.
- Back-pressure/full:
  - Hold out_ready=0 and push 6 pairs (1+1, 2+2, …) → 1 accepted into the output register plus 4 in the FIFO, in_ready=0, level=4.
  - Release out_ready → sums 2,4,6,8,10 delivered in order with no loss or duplication.
- Streaming: continuous in_valid and out_ready=1 over 100 random pairs → one sum per cycle after the initial latency, order preserved, level never exceeds 1.
- Full with simultaneous pop: FIFO full, out_ready=1, in_valid=1 → no push that cycle (in_ready=0), level drops to 3, push accepted next cycle.
- Reset mid-stream: assert rst_n=0 with level=3 and out_valid=1 → out_valid=0, out_sum=0, level=0 and in_ready=1 immediately (asynchronous); after release, no stale sums appear.
